tdm_demux4: RTL and testbench

Four-slot time-division demultiplexer: the receive end of a link where four 1-of-4 selected signals are serialised onto a shared wire, one slot per beat. It tracks slot position from a frame-sync marker, collects one beat per slot, and updates all four channel outputs together once a frame is complete. It sits downstream of the 4:1 mux stage and restores parallel channels a, b, c and d.

---
 rtl/tdm_demux4.sv | 117 +++++++++++
 tb/tb_tdm_demux4.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/tdm_demux4.sv
// Four-slot TDM demultiplexer: locks onto a frame-sync marker, collects one beat
// per slot and presents all four channels together once a frame is complete.
module tdm_demux4 #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  input  logic             sync_in,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] c,
  output logic [WIDTH-1:0] d,
  output logic             frame_valid,
  output logic [1:0]       slot,
  output logic             sync_err
);

  typedef enum logic {
    HUNT,
    RUN
  } state_e;

  state_e           state_q, state_d;
  logic [1:0]       slot_q, slot_d;
  logic [WIDTH-1:0] sha_q, sha_d, shb_q, shb_d, shc_q, shc_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, c_q, c_d, d_q, d_d;
  logic             fv_q, fv_d, err_q, err_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= HUNT;
      slot_q  <= 2'd0;
      sha_q   <= '0;
      shb_q   <= '0;
      shc_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= '0;
      d_q     <= '0;
      fv_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      slot_q  <= slot_d;
      sha_q   <= sha_d;
      shb_q   <= shb_d;
      shc_q   <= shc_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      d_q     <= d_d;
      fv_q    <= fv_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    slot_d  = slot_q;
    sha_d   = sha_q;
    shb_d   = shb_q;
    shc_d   = shc_q;
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
    d_d     = d_q;
    fv_d    = 1'b0;
    err_d   = 1'b0;

    if (din_valid) begin
      unique case (state_q)
        HUNT: begin
          if (sync_in) begin
            sha_d   = din;
            slot_d  = 2'd1;
            state_d = RUN;
          end
        end
        RUN: begin
          // A marker anywhere but slot 0 abandons the partial frame and restarts it.
          if (sync_in && (slot_q != 2'd0)) begin
            err_d  = 1'b1;
            sha_d  = din;
            slot_d = 2'd1;
          end else begin
            slot_d = slot_q + 2'd1;
            unique case (slot_q)
              2'd0: sha_d = din;
              2'd1: shb_d = din;
              2'd2: shc_d = din;
              2'd3: begin
                a_d  = sha_q;
                b_d  = shb_q;
                c_d  = shc_q;
                d_d  = din;
                fv_d = 1'b1;
              end
              default: ;
            endcase
          end
        end
        default: state_d = HUNT;
      endcase
    end
  end

  assign a           = a_q;
  assign b           = b_q;
  assign c           = c_q;
  assign d           = d_q;
  assign frame_valid = fv_q;
  assign slot        = slot_q;
  assign sync_err    = err_q;

endmodule

// File: tb/tb_tdm_demux4.sv
// Bench for tdm_demux4: drives a 1-bit and an 8-bit instance with the same beats
// and checks both against a frame-collecting reference every cycle.
module tb_tdm_demux4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] din = 8'h00;
  logic       dinValid = 1'b0;
  logic       syncIn = 1'b0;

  logic       a1, b1, c1, d1, fv1, err1;
  logic [1:0] slot1;
  logic [7:0] a8, b8, c8, d8;
  logic       fv8, err8;
  logic [1:0] slot8;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  tdm_demux4 #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .din(din[0]), .din_valid(dinValid), .sync_in(syncIn),
    .a(a1), .b(b1), .c(c1), .d(d1),
    .frame_valid(fv1), .slot(slot1), .sync_err(err1)
  );

  tdm_demux4 #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .din(din), .din_valid(dinValid), .sync_in(syncIn),
    .a(a8), .b(b8), .c(c8), .d(d8),
    .frame_valid(fv8), .slot(slot8), .sync_err(err8)
  );

  // Reference: a queue of beats collected since the last frame boundary.
  logic [7:0] beats[$];
  logic       locked = 1'b0;
  logic [7:0] mA = 8'h00, mB = 8'h00, mC = 8'h00, mD = 8'h00;
  logic       mFv = 1'b0, mErr = 1'b0;
  logic [1:0] mSlot = 2'd0;

  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      locked = 1'b0;
      beats.delete();
      mA = 8'h00; mB = 8'h00; mC = 8'h00; mD = 8'h00;
      mFv = 1'b0; mErr = 1'b0;
    end else begin
      mFv = 1'b0;
      mErr = 1'b0;
      if (dinValid) begin
        if (!locked) begin
          if (syncIn) begin
            locked = 1'b1;
            beats.delete();
            beats.push_back(din);
          end
        end else if (syncIn && beats.size() != 0) begin
          mErr = 1'b1;
          beats.delete();
          beats.push_back(din);
        end else begin
          beats.push_back(din);
          if (beats.size() == 4) begin
            mA = beats[0]; mB = beats[1]; mC = beats[2]; mD = beats[3];
            mFv = 1'b1;
            beats.delete();
          end
        end
      end
    end
    mSlot = 2'(beats.size());
  end

  task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, actual, expected, $time);
    end
  endtask

  initial forever begin
    @(negedge clk);
    checkOutput("a1", {7'b0, a1}, {7'b0, mA[0]});
    checkOutput("b1", {7'b0, b1}, {7'b0, mB[0]});
    checkOutput("c1", {7'b0, c1}, {7'b0, mC[0]});
    checkOutput("d1", {7'b0, d1}, {7'b0, mD[0]});
    checkOutput("fv1", {7'b0, fv1}, {7'b0, mFv});
    checkOutput("err1", {7'b0, err1}, {7'b0, mErr});
    checkOutput("slot1", {6'b0, slot1}, {6'b0, mSlot});
    checkOutput("a8", a8, mA);
    checkOutput("b8", b8, mB);
    checkOutput("c8", c8, mC);
    checkOutput("d8", d8, mD);
    checkOutput("fv8", {7'b0, fv8}, {7'b0, mFv});
    checkOutput("err8", {7'b0, err8}, {7'b0, mErr});
    checkOutput("slot8", {6'b0, slot8}, {6'b0, mSlot});
  end

  task automatic applyStimulus(input logic [7:0] data, input logic valid, input logic sync);
    @(negedge clk);
    din = data;
    dinValid = valid;
    syncIn = sync;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(8'h00, 1'b0, 1'b0);
  endtask

  task automatic checkFrame8(input string name, input logic [7:0] ea, input logic [7:0] eb,
                             input logic [7:0] ec, input logic [7:0] ed);
    checkOutput({name, "_a"}, a8, ea);
    checkOutput({name, "_b"}, b8, eb);
    checkOutput({name, "_c"}, c8, ec);
    checkOutput({name, "_d"}, d8, ed);
  endtask

  initial begin
    // Reset and hold, then non-sync beats that HUNT must ignore.
    idle(3);
    rst = 1'b0;
    idle(2);
    applyStimulus(8'h01, 1'b1, 1'b0);
    applyStimulus(8'h01, 1'b1, 1'b0);
    idle(1);
    checkOutput("hunt_slot", {6'b0, slot1}, 8'h00);
    checkOutput("hunt_fv", {7'b0, fv1}, 8'h00);
    checkFrame8("hunt", 8'h00, 8'h00, 8'h00, 8'h00);

    // Basic frame 1(sync),0,1,0.
    applyStimulus(8'h01, 1'b1, 1'b1);
    applyStimulus(8'h00, 1'b1, 1'b0);
    applyStimulus(8'h01, 1'b1, 1'b0);
    applyStimulus(8'h00, 1'b1, 1'b0);
    idle(1);
    checkOutput("basic_abcd", {4'b0, a1, b1, c1, d1}, 8'h0A);
    checkOutput("basic_fv", {7'b0, fv1}, 8'h01);
    checkOutput("basic_slot", {6'b0, slot1}, 8'h00);
    idle(1);
    checkOutput("basic_fv_drop", {7'b0, fv1}, 8'h00);

    // Gapped frame with stray sync during gaps, then a sync-less frame.
    applyStimulus(8'h01, 1'b1, 1'b1);
    applyStimulus(8'h00, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus(8'h00, 1'b0, 1'b1);
    applyStimulus(8'h01, 1'b1, 1'b0);
    applyStimulus(8'h00, 1'b1, 1'b0);
    idle(1);
    checkOutput("gap_abcd", {4'b0, a1, b1, c1, d1}, 8'h0A);
    applyStimulus(8'h00, 1'b1, 1'b0);
    applyStimulus(8'h01, 1'b1, 1'b0);
    applyStimulus(8'h00, 1'b1, 1'b0);
    applyStimulus(8'h01, 1'b1, 1'b0);
    idle(1);
    checkOutput("nosync_abcd", {4'b0, a1, b1, c1, d1}, 8'h05);

    // Resync: 1(sync),1, then 0(sync),1,1,1.
    applyStimulus(8'h01, 1'b1, 1'b1);
    applyStimulus(8'h01, 1'b1, 1'b0);
    applyStimulus(8'h00, 1'b1, 1'b1);
    applyStimulus(8'h01, 1'b1, 1'b0);
    checkOutput("resync_err", {7'b0, err1}, 8'h01);
    checkOutput("resync_nofv", {7'b0, fv1}, 8'h00);
    applyStimulus(8'h01, 1'b1, 1'b0);
    applyStimulus(8'h01, 1'b1, 1'b0);
    idle(1);
    checkOutput("resync_abcd", {4'b0, a1, b1, c1, d1}, 8'h07);
    checkOutput("resync_fv", {7'b0, fv1}, 8'h01);

    // Reset mid-frame, asserted between edges.
    applyStimulus(8'h01, 1'b1, 1'b1);
    applyStimulus(8'h01, 1'b1, 1'b0);
    idle(1);
    #2 rst = 1'b1;
    #1;
    checkOutput("rst_abcd", {4'b0, a1, b1, c1, d1}, 8'h00);
    checkOutput("rst_slot", {6'b0, slot1}, 8'h00);
    idle(1);
    rst = 1'b0;
    applyStimulus(8'h00, 1'b1, 1'b1);
    applyStimulus(8'h00, 1'b1, 1'b0);
    applyStimulus(8'h01, 1'b1, 1'b0);
    applyStimulus(8'h01, 1'b1, 1'b0);
    idle(1);
    checkOutput("postrst_abcd", {4'b0, a1, b1, c1, d1}, 8'h03);

    // Wide data frame.
    applyStimulus(8'hA5, 1'b1, 1'b1);
    applyStimulus(8'h3C, 1'b1, 1'b0);
    applyStimulus(8'hFF, 1'b1, 1'b0);
    applyStimulus(8'h00, 1'b1, 1'b0);
    idle(1);
    checkFrame8("wide", 8'hA5, 8'h3C, 8'hFF, 8'h00);
    checkOutput("wide_fv", {7'b0, fv8}, 8'h01);
    idle(3);
    checkFrame8("wide_hold", 8'hA5, 8'h3C, 8'hFF, 8'h00);
    checkOutput("wide_fv_hold", {7'b0, fv8}, 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
